route_requester: RTL and testbench

ROUTE_REQUESTER -- requirements
Module: route_requester

---
 rtl/route_requester.sv | 186 ++++++++++++++++++
 tb/tb_route_requester.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_requester.sv
// Per-input route requester: buffers flits, reserves a crossbar path per packet, forwards the packet, then releases the path.
// Optional feature: define ROUTE_REQ_TIMEOUT_EN to enable the sticky req_timeout flag.
module route_requester #(
   parameter int DATA_WIDTH    = 8,
   parameter int REQUEST_WIDTH = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int TIMEOUT       = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     routeReserveRequestValid,
   output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
   input  logic                     routeReserveStatus,
   input  logic                     PortReserved,
   output logic                     routeRelieve,
   output logic                     drop_pulse,
   output logic                     req_timeout,
   output logic [2:0]               dbg_state
);

   // Handshakes: a transfer happens on any rising edge where valid and ready are both 1;
   // valid never depends on ready, and data is stable while valid is held.

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQUEST  = 3'd1,
      S_WAIT_RSV = 3'd2,
      S_FORWARD  = 3'd3,
      S_RELIEVE  = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [REQUEST_WIDTH-1:0] port_q, port_d;
   logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    mem_d [FIFO_DEPTH];
   logic [AW:0]              wr_ptr_q, wr_ptr_d;
   logic [AW:0]              rd_ptr_q, rd_ptr_d;

   logic                     fifo_empty;
   logic                     fifo_full;
   logic                     push;
   logic                     pop;
   logic [DATA_WIDTH-1:0]    head;
   logic [1:0]               head_type;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready   = !fifo_full;
   assign push       = in_valid && in_ready;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign head_type  = head[DATA_WIDTH-1:DATA_WIDTH-2];
   assign out_data   = head;

   assign routeReserveRequest = port_q;
   assign dbg_state           = state_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = in_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Type bit 0 marks packet start (head/single); type bit 1 marks packet end (tail/single).
   always_comb begin
      state_d                  = state_q;
      port_d                   = port_q;
      pop                      = 1'b0;
      drop_pulse               = 1'b0;
      routeReserveRequestValid = 1'b0;
      routeRelieve             = 1'b0;
      out_valid                = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               if (head_type[0]) begin
                  port_d  = head[REQUEST_WIDTH-1:0];
                  state_d = S_REQUEST;
               end else begin
                  pop        = 1'b1;
                  drop_pulse = 1'b1;
               end
            end
         end
         S_REQUEST: begin
            routeReserveRequestValid = 1'b1;
            if (routeReserveStatus) begin
               state_d = S_WAIT_RSV;
            end
         end
         S_WAIT_RSV: begin
            routeReserveRequestValid = 1'b1;
            if (PortReserved) begin
               state_d = S_FORWARD;
            end
         end
         S_FORWARD: begin
            routeReserveRequestValid = 1'b1;
            out_valid                = !fifo_empty;
            if (!fifo_empty && out_ready) begin
               pop = 1'b1;
               if (head_type[1]) begin
                  state_d = S_RELIEVE;
               end
            end
         end
         S_RELIEVE: begin
            routeRelieve = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         port_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         port_q   <= port_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef ROUTE_REQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          req_timeout_q, req_timeout_d;

   always_comb begin
      to_cnt_d      = to_cnt_q;
      req_timeout_d = req_timeout_q;
      if (state_q == S_IDLE && state_d == S_REQUEST) begin
         to_cnt_d = '0;
      end else if ((state_q == S_REQUEST || state_q == S_WAIT_RSV) &&
                   (to_cnt_q != TW'(TIMEOUT))) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
      if (to_cnt_d == TW'(TIMEOUT)) begin
         req_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q      <= '0;
         req_timeout_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         req_timeout_q <= req_timeout_d;
      end
   end

   assign req_timeout = req_timeout_q;
`else
   assign req_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_route_requester.sv
// Directed bench for route_requester: packet forwarding, drops, back-pressure, mid-packet reset, timeout flag.
module tb_route_requester;

   localparam int DW = 8;
   localparam int RW = 2;
`ifdef ROUTE_REQ_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          rrv;
   logic [RW-1:0] rreq;
   logic          status;
   logic          reserved;
   logic          relieve;
   logic          drop;
   logic          timeout_flag;
   logic [2:0]    dbg_state;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] pk [6];

   always #5 clk = ~clk;

   route_requester #(
      .DATA_WIDTH(DW), .REQUEST_WIDTH(RW), .FIFO_DEPTH(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .routeReserveRequestValid(rrv), .routeReserveRequest(rreq),
      .routeReserveStatus(status), .PortReserved(reserved),
      .routeRelieve(relieve), .drop_pulse(drop),
      .req_timeout(timeout_flag), .dbg_state(dbg_state)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int outs;
      int rel;
      in_valid = 0; in_data = '0; out_ready = 0; status = 0; reserved = 0;
      pk[0] = 8'h43; pk[1] = 8'h01; pk[2] = 8'h02;
      pk[3] = 8'h03; pk[4] = 8'h04; pk[5] = 8'h85;

      // reset state
      tick(); #1;
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_rrv", rrv, 0);
      check_val("rst_req", rreq, 0);
      check_val("rst_relieve", relieve, 0);
      check_val("rst_drop", drop, 0);
      check_val("rst_timeout", timeout_flag, 0);
      check_val("rst_state", dbg_state, 0);
      rst = 0;

      // head(port 2), body, tail
      tick(); in_valid = 1; in_data = 8'h42; #1;
      check_val("p1_idle_rrv", rrv, 0);
      tick(); in_data = 8'h15; #1;
      check_val("p1_idle_rrv2", rrv, 0);
      tick(); in_data = 8'h8A; #1;
      check_val("p1_req_rrv", rrv, 1);
      check_val("p1_req_port", rreq, 2);
      check_val("p1_req_outv", out_valid, 0);
      tick(); in_valid = 0; status = 1; #1;
      check_val("p1_req_rrv2", rrv, 1);
      tick(); status = 0; reserved = 1; #1;
      check_val("p1_wait_outv", out_valid, 0);
      check_val("p1_wait_rrv", rrv, 1);
      tick(); out_ready = 1; #1;
      check_val("p1_fwd_v0", out_valid, 1);
      check_val("p1_fwd_d0", out_data, 8'h42);
      tick(); #1;
      check_val("p1_fwd_d1", out_data, 8'h15);
      check_val("p1_fwd_port", rreq, 2);
      tick(); #1;
      check_val("p1_fwd_d2", out_data, 8'h8A);
      check_val("p1_fwd_rel", relieve, 0);
      tick(); #1;
      check_val("p1_rel", relieve, 1);
      check_val("p1_rel_rrv", rrv, 0);
      check_val("p1_rel_outv", out_valid, 0);
      check_val("p1_rel_port", rreq, 2);
      tick(); reserved = 0; out_ready = 0; #1;
      check_val("p1_after_rel", relieve, 0);
      check_val("p1_after_state", dbg_state, 0);

      // single flit, port 1
      tick(); in_valid = 1; in_data = 8'hC1; #1;
      tick(); in_valid = 0; #1;
      check_val("p2_idle_rrv", rrv, 0);
      tick(); status = 1; #1;
      check_val("p2_req_rrv", rrv, 1);
      check_val("p2_req_port", rreq, 1);
      tick(); status = 0; reserved = 1; #1;
      check_val("p2_wait_outv", out_valid, 0);
      tick(); out_ready = 1; #1;
      check_val("p2_fwd_v", out_valid, 1);
      check_val("p2_fwd_d", out_data, 8'hC1);
      tick(); out_ready = 0; reserved = 0; #1;
      check_val("p2_rel", relieve, 1);
      check_val("p2_rel_rrv", rrv, 0);
      check_val("p2_rel_outv", out_valid, 0);
      tick(); #1;
      check_val("p2_after_rel", relieve, 0);

      // stray body flit while idle
      tick(); in_valid = 1; in_data = 8'h05; #1;
      tick(); in_valid = 0; #1;
      check_val("p3_drop", drop, 1);
      check_val("p3_rrv", rrv, 0);
      tick(); #1;
      check_val("p3_drop_once", drop, 0);
      check_val("p3_rrv2", rrv, 0);
      check_val("p3_state", dbg_state, 0);

      // six flits into a 4-deep FIFO with status withheld
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         tick(); in_valid = 1; in_data = pk[idx]; #1;
         if (!in_ready) break;
         exp_q.push_back(pk[idx]);
         idx++;
         if (idx == 6) break;
      end
      check_val("p4_accepted", idx, 4);
      check_val("p4_full_ready", in_ready, 0);
      check_val("p4_rrv", rrv, 1);
      check_val("p4_port", rreq, 3);
      outs = 0; rel = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         status = (c == 0);
         reserved = (c >= 1);
         out_ready = 1;
         in_valid = (idx < 6);
         in_data = (idx < 6) ? pk[idx] : '0;
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(pk[idx]);
            idx++;
         end
         if (out_valid) begin
            outs++;
            if (exp_q.size() == 0) check_val("p4_extra_flit", out_data, 0 - 1);
            else check_val("p4_data", out_data, exp_q.pop_front());
         end
         if (relieve) begin
            rel++;
            break;
         end
      end
      check_val("p4_out_count", outs, 6);
      check_val("p4_rel_count", rel, 1);
      check_val("p4_all_in", idx, 6);
      tick(); status = 0; reserved = 0; in_valid = 0; out_ready = 0; #1;
      check_val("p4_after_rel", relieve, 0);

      // reset mid-packet in FORWARD
      tick(); in_valid = 1; in_data = 8'h42; #1;
      tick(); in_data = 8'h15; #1;
      tick(); in_valid = 0; status = 1; #1;
      tick(); status = 0; reserved = 1; #1;
      tick(); out_ready = 1; #1;
      check_val("p5_head_d", out_data, 8'h42);
      tick(); out_ready = 0; #1;
      check_val("p5_body_d", out_data, 8'h15);
      rst = 1; #1;
      check_val("p5_rst_outv", out_valid, 0);
      check_val("p5_rst_rrv", rrv, 0);
      check_val("p5_rst_req", rreq, 0);
      check_val("p5_rst_rel", relieve, 0);
      check_val("p5_rst_ready", in_ready, 1);
      tick(); rst = 0; reserved = 0; #1;
      check_val("p5_post_rel", relieve, 0);
      check_val("p5_post_drop", drop, 0);
      tick(); #1;
      check_val("p5_post_rel2", relieve, 0);
      check_val("p5_post_drop2", drop, 0);
      check_val("p5_post_outv", out_valid, 0);

      // timeout flag: starts clear after reset, rises after 8 cycles in REQUEST
      tick(); rst = 1; #1;
      check_val("p6_rst_to", timeout_flag, 0);
      tick(); rst = 0; in_valid = 1; in_data = 8'hC2; #1;
      tick(); in_valid = 0; #1;
      for (int k = 0; k < 8; k++) begin
         tick(); #1;
      end
      check_val("p6_to_7", timeout_flag, 0);
      tick(); #1;
      check_val("p6_to_8", timeout_flag, TO_EN);
      tick(); status = 1; #1;
      check_val("p6_rrv", rrv, 1);
      tick(); status = 0; reserved = 1; #1;
      tick(); out_ready = 1; #1;
      check_val("p6_fwd_d", out_data, 8'hC2);
      tick(); out_ready = 0; reserved = 0; #1;
      check_val("p6_rel", relieve, 1);
      check_val("p6_to_sticky", timeout_flag, TO_EN);
      tick(); #1;
      check_val("p6_to_sticky2", timeout_flag, TO_EN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
